// File: rtl/uart_rx_fifo.sv
// UART receiver with a synchronizer, a bit-sampling FSM and a small receive FIFO.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int BAUD_PERIOD = 868,
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_ODD  = 0
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          rx,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err,
    input  logic                          clr_err
);

    localparam int CW = $clog2(BAUD_PERIOD);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_HALF = CW'((BAUD_PERIOD >> 1) - 1);
    localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_PERIOD - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 16 || BAUD_PERIOD < 4 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
            $error("uart_rx_fifo: illegal parameter value");
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  r_state, w_state_next;
    logic                    r_s1, r_s2, r_s3;
    logic [CW-1:0]           r_baud;
    logic [BW-1:0]           r_bitcnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_frame_err, r_overrun_err;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
    logic [AW:0]             r_count;
    logic                    w_start_det, w_sample, w_stop_sample;
    logic                    w_pop, w_push, w_good, w_set_frame, w_set_ovr;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= rx;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A falling edge is required, so a held-low break never retriggers a frame.
    assign w_start_det = r_s3 & ~r_s2;
    assign w_sample    = (r_state != IDLE) && (r_baud == '0);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_stop_sample = 1'b0;
        case (r_state)
            IDLE:  if (w_start_det) w_state_next = START;
            START: if (w_sample) w_state_next = r_s2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (w_sample && r_bitcnt == LAST_BIT) w_state_next = PARITY;
            PARITY: if (w_sample) w_state_next = STOP;
`else
            DATA:   if (w_sample && r_bitcnt == LAST_BIT) w_state_next = STOP;
`endif
            STOP: begin
                if (w_sample) begin
                    w_state_next  = IDLE;
                    w_stop_sample = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, r_parity_err, w_set_par;
    assign w_set_par  = w_stop_sample & r_s2 & r_par_bad;
    assign w_good     = w_stop_sample & r_s2 & ~r_par_bad;
    assign parity_err = r_parity_err;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_sample && r_state == PARITY)
                r_par_bad <= r_s2 ^ (^r_shift) ^ (PARITY_ODD != 0);
            if (w_set_par)    r_parity_err <= 1'b1;
            else if (clr_err) r_parity_err <= 1'b0;
        end
    end
`else
    assign w_good     = w_stop_sample & r_s2;
    assign parity_err = 1'b0;
`endif

    assign w_pop       = rx_valid & rx_ready;
    assign w_set_frame = w_stop_sample & ~r_s2;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_set_ovr   = w_good & (r_count == FIFO_FULL) & ~w_pop;
    assign w_push      = w_good & ((r_count != FIFO_FULL) | w_pop);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_baud        <= '0;
            r_bitcnt      <= '0;
            r_shift       <= '0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (w_start_det) r_baud <= BAUD_HALF;
            end else if (r_baud == '0) begin
                r_baud <= BAUD_FULL;
            end else begin
                r_baud <= r_baud - 1'b1;
            end

            if (w_sample && r_state == START) r_bitcnt <= '0;
            if (w_sample && r_state == DATA) begin
                r_shift  <= {r_s2, r_shift[DATA_WIDTH-1:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            if (w_set_frame)  r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
            if (w_set_ovr)    r_overrun_err <= 1'b1;
            else if (clr_err) r_overrun_err <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift;
    end

    assign rx_valid    = (r_count != '0);
    assign rx_data     = rx_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count  = r_count;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_uart_rx_fifo;

    localparam int DW = 8;
    localparam int BP = 16;
    localparam int FD = 4;
    localparam int PODD = 0;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [2:0]    fifo_count;
    logic          frame_err, overrun_err, parity_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    logic [DW-1:0] m_q[$];
    bit m_frame = 0, m_ovr = 0, m_par = 0;

    uart_rx_fifo #(.DATA_WIDTH(DW), .BAUD_PERIOD(BP), .FIFO_DEPTH(FD), .PARITY_ODD(PODD)) dut (
        .clk(clk), .rst_l(rst_l), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_count(fifo_count), .frame_err(frame_err),
        .overrun_err(overrun_err), .parity_err(parity_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: outcome of one frame at its stop-sample edge.
    task automatic model_frame(input logic [DW-1:0] d, input bit stop_ok, input bit par_ok, input bit pop);
        if (!stop_ok) m_frame = 1;
        else if (!par_ok) m_par = 1;
        else if (m_q.size() == FD && !pop) m_ovr = 1;
        else begin
            if (pop && m_q.size() != 0) void'(m_q.pop_front());
            m_q.push_back(d);
        end
        if (!(stop_ok && par_ok) && pop && m_q.size() != 0) void'(m_q.pop_front());
    endtask

    // Starts right after a posedge; stop bit is sampled 155 (171 with parity) edges later.
    task automatic send_frame(input logic [DW-1:0] d, input bit stop_bit, input bit par_bit, input bit pop_at_stop);
        bit par_ok;
        par_ok = 1;
        rx = 1'b0;
        repeat (BP) tick();
        for (int k = 0; k < DW; k++) begin
            rx = d[k];
            repeat (BP) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        par_ok = (par_bit == ((^d) ^ (PODD != 0)));
        repeat (BP) tick();
`else
        par_ok = par_bit | 1'b1;
`endif
        rx = stop_bit;
        repeat (10) tick();
        if (pop_at_stop) rx_ready = 1'b1;
        tick();
        model_frame(d, stop_bit, par_ok, pop_at_stop);
        rx_ready = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
    endtask

    task automatic pop_expect(input string name, input logic [DW-1:0] exp);
        chk(name, int'(rx_data), int'(exp));
        rx_ready = 1'b1;
        tick();
        if (m_q.size() != 0) void'(m_q.pop_front());
        rx_ready = 1'b0;
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        tick();
        m_frame = 0; m_ovr = 0; m_par = 0;
        clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", int'(rx_valid), int'(m_q.size() != 0));
            chk("cyc_count", int'(fifo_count), m_q.size());
            if (m_q.size() != 0) chk("cyc_data", int'(rx_data), int'(m_q[0]));
            chk("cyc_frame_err", int'(frame_err), int'(m_frame));
            chk("cyc_overrun_err", int'(overrun_err), int'(m_ovr));
            chk("cyc_parity_err", int'(parity_err), int'(m_par));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_errs", int'({frame_err, overrun_err, parity_err}), 0);
        #2 rst_l = 1'b1;
        cmp_en = 1'b1;
        repeat (4) tick();

        // Single word, then one pop.
        send_frame(8'hA5, 1, 1, 0);
        chk("a5_valid", int'(rx_valid), 1);
        chk("a5_data", int'(rx_data), 8'hA5);
        chk("a5_count", int'(fifo_count), 1);
        chk("a5_errs", int'({frame_err, overrun_err, parity_err}), 0);
        pop_expect("a5_pop", 8'hA5);
        chk("a5_empty", int'(rx_valid), 0);

        // Five back-to-back frames into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(DW'(i), 1, 1, 0);
        chk("ovr_count", int'(fifo_count), 4);
        chk("ovr_flag", int'(overrun_err), 1);
        clear_errs();
        chk("ovr_cleared", int'(overrun_err), 0);
        for (int i = 1; i <= 4; i++) pop_expect("ovr_pop", DW'(i));
        chk("ovr_drained", int'(fifo_count), 0);

        // Full FIFO with a pop on the stop-sample cycle: word accepted, no overrun.
        for (int i = 0; i < 4; i++) send_frame(DW'(8'h11 + i), 1, 1, 0);
        send_frame(8'h15, 1, 1, 1);
        chk("fullpop_count", int'(fifo_count), 4);
        chk("fullpop_ovr", int'(overrun_err), 0);
        for (int i = 0; i < 4; i++) pop_expect("fullpop_pop", DW'(8'h12 + i));

        // Short glitch is a false start.
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (30) tick();
        chk("glitch_count", int'(fifo_count), 0);
        chk("glitch_errs", int'({frame_err, overrun_err, parity_err}), 0);
        send_frame(8'h66, 1, 1, 0);
        pop_expect("glitch_next", 8'h66);

        // Low stop bit.
        send_frame(8'h3C, 0, 1, 0);
        chk("frame_flag", int'(frame_err), 1);
        chk("frame_nopush", int'(fifo_count), 0);
        repeat (4) tick();
        clear_errs();
        chk("frame_cleared", int'(frame_err), 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 1, 0);
        chk("par_good_count", int'(fifo_count), 1);
        send_frame(8'h07, 1, 0, 0);
        chk("par_bad_flag", int'(parity_err), 1);
        chk("par_bad_count", int'(fifo_count), 1);
        pop_expect("par_pop", 8'h07);
        clear_errs();
`endif

        // Reset in the middle of the data bits.
        send_frame(8'h21, 1, 1, 0);
        send_frame(8'h22, 1, 1, 0);
        chk("pre_rst_count", int'(fifo_count), 2);
        rx = 1'b0;
        repeat (BP) tick();
        rx = 1'b1;
        repeat (40) tick();
        #2 rst_l = 1'b0;
        m_q.delete();
        m_frame = 0; m_ovr = 0; m_par = 0;
        #1;
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_valid", int'(rx_valid), 0);
        repeat (3) tick();
        #2 rst_l = 1'b1;
        repeat (4) tick();
        send_frame(8'h5A, 1, 1, 0);
        chk("post_rst_data", int'(rx_data), 8'h5A);
        chk("post_rst_count", int'(fifo_count), 1);
        pop_expect("post_rst_pop", 8'h5A);
        repeat (4) tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable word width, optional parity, framing/overrun error detection and a receive FIFO with a valid/ready output. It sits between the serial `rx` pin and the memory-side command logic, replacing the single-word receiver that required software to clear a done flag. Characters queue in the FIFO, so back-to-back frames are not lost while the consumer is stalled.

## Interface
- Reset `rst_l` is asynchronous and active-low; the clock is `clk`.

Parameters:
- `DATA_WIDTH`, default 8: data bits per frame, valid range 5–16.
- `BAUD_PERIOD`, default 868: clk cycles per bit, minimum 4.
- `FIFO_DEPTH`, default 4: receive FIFO entries, a power of two, minimum 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk` in 1: clock.
- `rst_l` in 1: async active-low reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `rx_data` out DATA_WIDTH: FIFO head word, LSB = first received bit.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer accepts head; pop when `rx_valid & rx_ready`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `frame_err` out 1: sticky; set when a stop bit is sampled low.
- `overrun_err` out 1: sticky; set when a good frame arrives with the FIFO full and no pop.
- `parity_err` out 1: sticky; set on parity mismatch. Tied 0 when parity is compiled out.
- `clr_err` in 1: clears all sticky errors.

## Operation
- `rx` passes through three flops (`s1`, `s2`, `s3`), each reset to 1. A start is detected in IDLE when `s3 & ~s2`. Sampling uses `s2`.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE → START on start detect. The baud counter loads `(BAUD_PERIOD>>1)-1`.
- The baud counter decrements each cycle outside IDLE. The cycle with count 0 is a sample cycle, and the counter reloads `BAUD_PERIOD-1`.
- START sample:
  - `s2==1`: false start, go to IDLE with no side effects.
  - Otherwise go to DATA with the bit counter at 0.
- DATA: on each sample, shift `s2` into the MSB of the shift register (the LSB arrives first). After `DATA_WIDTH` samples, go to PARITY if enabled, else STOP.
- PARITY: sample the parity bit and compare it against the XOR of the data, inverted if `PARITY_ODD`. Then go to STOP.
- STOP sample, always → IDLE:
  - If the stop bit is low: set `frame_err` and discard the word.
  - Else if parity mismatched: set `parity_err` and discard the word.
  - Else if the FIFO is full and no pop occurs this cycle: set `overrun_err` and discard the new word. FIFO contents are unchanged.
  - Else push the word.
- A new start can be detected from the cycle after the STOP sample. A low stop bit (break) suppresses detection until `rx` returns high, because an edge is required.
- FIFO rules:
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push and a pop in the same cycle leave `fifo_count` unchanged, including when the FIFO is full.
  - A pop while empty is ignored.
  - `rx_data` is held stable while `rx_valid & ~rx_ready`.
- Error flags: any set has priority over `clr_err` in the same cycle.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=0, `fifo_count`=0, all error flags 0, state IDLE, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame and empties the FIFO. The partial word is never pushed.
- Start detect occurs 3 clk edges after `rx` falls.
- The START sample falls `BAUD_PERIOD>>1` cycles after detect. Each later sample follows the previous by `BAUD_PERIOD` cycles.
- The pushed word appears on `rx_data` and `rx_valid` rises in the cycle after the STOP sample, when the FIFO was empty.
- A sticky flag is visible the cycle after the STOP sample.
- Pop takes effect on the clock edge. The next head word, or `rx_valid`=0, is visible in the following cycle.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the frame is 1 start + `DATA_WIDTH` data + 1 parity + 1 stop bit. The PARITY state exists, `parity_err` is live, and `PARITY_ODD` selects the sense.
  - Undefined: the frame is 1 start + `DATA_WIDTH` + 1 stop bit. The PARITY state and its logic are absent, `parity_err` is constant 0, and `PARITY_ODD` is ignored.

## Test plan
All scenarios use `BAUD_PERIOD`=16, `DATA_WIDTH`=8, `FIFO_DEPTH`=4.

- Send 0xA5 with `rx_ready`=1 held off → `rx_valid`=1, `rx_data`=0xA5, `fifo_count`=1, no errors. Assert `rx_ready` for one cycle → `rx_valid`=0.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with no pops → the FIFO holds 0x01–0x04 and `fifo_count`=4. `overrun_err`=1 after the 5th stop bit. Popping four times returns 0x01..0x04 in order.
- Drive a 4-cycle low glitch on `rx` → false start, no push, no error, state returns to IDLE.
- Send 0x3C with the stop bit forced low → `frame_err`=1, no push. Pulse `clr_err` → `frame_err`=0.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0: send 0x07 with parity bit 1 → pushed. Send 0x07 with parity bit 0 → `parity_err`=1, no push.
- Assert `rst_l`=0 mid-way through the DATA bits with `fifo_count`=2 → `fifo_count`=0 and `rx_valid`=0 immediately. After release, a fresh 0x5A is received correctly.
